// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and state type for the register-bank write arbiter
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first set request at or after ptr, wrapping
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [1:0]   gnt_idx,
  output logic         gnt_valid
);

  logic [2:0] sum;
  logic [1:0] cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      // ptr + off never exceeds 2*N-2, so one subtraction is enough to wrap
      sum = {1'b0, ptr} + 3'(off);
      if (sum >= 3'(N)) begin
        sum = sum - 3'(N);
      end
      cand = sum[1:0];
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register bank write port among NREQ requesters
// and runs the x1..x31 clear sequence; bank write inputs come straight from flops.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int AW   = regfile_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic                 we3,
  output logic [AW-1:0]        wa3,
  output logic [XLEN-1:0]      wd3,
  output logic [1:0]           grant_id
);

  import regfile_pkg::*;

  wb_state_t       state_q, state_d;
  logic            we3_q, we3_d;
  logic [AW-1:0]   wa3_q, wa3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;

  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_idx;
  logic            gnt_valid;
  logic [NREQ-1:0] ready_int;

  logic [AW-1:0]   addr_arr [NREQ];
  logic [XLEN-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*AW +: AW];
    assign data_arr[i] = req_data[i*XLEN +: XLEN];
  end

  rr_arbiter #(
    .N(NREQ)
  ) u_rr_arbiter (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always_comb begin
    state_d    = state_q;
    we3_d      = 1'b0;
    wa3_d      = wa3_q;
    wd3_d      = wd3_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    clr_cnt_d  = clr_cnt_q;
    ready_int  = '0;

    case (state_q)
      RUN: begin
        if (clr_start) begin
          // clear takes priority: no handshake in the cycle it starts
          state_d   = CLEAR;
          we3_d     = 1'b1;
          wa3_d     = AW'(1);
          wd3_d     = '0;
          clr_cnt_d = AW'(1);
        end else if (gnt_valid) begin
          ready_int  = gnt;
          we3_d      = (addr_arr[gnt_idx] != '0);
          wa3_d      = addr_arr[gnt_idx];
          wd3_d      = data_arr[gnt_idx];
          grant_id_d = gnt_idx;
          rr_ptr_d   = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
        end
      end

      CLEAR: begin
        if (clr_cnt_q == AW'(NREGS - 1)) begin
          state_d   = RUN;
          clr_cnt_d = '0;
        end else begin
          we3_d     = 1'b1;
          wa3_d     = clr_cnt_q + AW'(1);
          wd3_d     = '0;
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      we3_q      <= 1'b0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      clr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      we3_q      <= we3_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      clr_cnt_q  <= clr_cnt_d;
    end
  end

  // ready is combinational, so it must also drop as soon as reset asserts
  assign req_ready = rst ? ready_int : '0;
  assign clr_busy  = (state_q == CLEAR);
  assign we3       = we3_q;
  assign wa3       = wa3_q;
  assign wd3       = wd3_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 clr_start;
  logic                 clr_busy;
  logic                 we3;
  logic [AW-1:0]        wa3;
  logic [XLEN-1:0]      wd3;
  logic [1:0]           grant_id;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic [1:0]      gid;
    logic            busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_write_arbiter #(
    .NREQ(NREQ),
    .XLEN(XLEN),
    .AW  (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_data (req_data),
    .clr_start(clr_start),
    .clr_busy (clr_busy),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                      input logic [1:0] gid, input logic busy);
    exp_t e;
    e.we = we; e.wa = wa; e.wd = wd; e.gid = gid; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    req_addr[i*AW +: AW]     = a;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  // Called just after a rising edge with inputs driven: checks ready mid-cycle,
  // then after the next edge compares the bank outputs with the scoreboard head.
  task automatic tick(input logic [NREQ-1:0] exp_rdy, input string tag);
    exp_t e;
    exp_t obs;
    #3;
    chk({tag, ".ready"}, 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    obs = {we3, wa3, wd3, grant_id, clr_busy};
    if (exp_q.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".out"}, 64'(obs), 64'(e));
    end
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    clr_start = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.out", 64'({we3, wa3, wd3, grant_id, clr_busy}), 64'(0));
    chk("reset.ready", 64'(req_ready), 64'(0));
    rst = 1'b1;

    // single requester 0
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    push(1'b1, 5'd5, 32'hDEADBEEF, 2'd0, 1'b0);
    tick(3'b001, "single0");
    req_valid = 3'b000;
    push(1'b0, 5'd5, 32'hDEADBEEF, 2'd0, 1'b0);
    tick(3'b000, "idle_hold");

    // requester 2 alone: pointer is 1, so it wins and the pointer wraps to 0
    set_req(2, 5'd7, 32'hA5A5A5A5);
    req_valid = 3'b100;
    push(1'b1, 5'd7, 32'hA5A5A5A5, 2'd2, 1'b0);
    tick(3'b100, "single2");

    // all three valid from pointer 0
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(10 + i), 32'h1000 + 32'(i));
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      push(1'b1, 5'(10 + k % 3), 32'h1000 + 32'(k % 3), 2'(k % 3), 1'b0);
      tick(3'(1 << (k % 3)), $sformatf("rr%0d", k));
    end

    // write to x0: accepted but no strobe, pointer advances to 2
    req_valid = 3'b010;
    set_req(1, 5'd0, 32'h12345678);
    push(1'b0, 5'd0, 32'h12345678, 2'd1, 1'b0);
    tick(3'b010, "addr0");
    req_valid = 3'b111;
    push(1'b1, 5'd12, 32'h1002, 2'd2, 1'b0);
    tick(3'b100, "ptr_after_addr0");

    // clear with a pending request from requester 2
    set_req(2, 5'd20, 32'hCAFEF00D);
    req_valid = 3'b100;
    clr_start = 1'b1;
    push(1'b1, 5'd1, 32'h0, 2'd2, 1'b1);
    tick(3'b000, "clr_start");
    clr_start = 1'b0;
    for (int k = 2; k <= 31; k++) begin
      clr_start = (k == 15);
      push(1'b1, 5'(k), 32'h0, 2'd2, 1'b1);
      tick(3'b000, $sformatf("clr%0d", k));
    end
    clr_start = 1'b0;
    push(1'b0, 5'd31, 32'h0, 2'd2, 1'b0);
    tick(3'b000, "clr_exit");
    push(1'b1, 5'd20, 32'hCAFEF00D, 2'd2, 1'b0);
    tick(3'b100, "post_clr_req2");
    req_valid = 3'b000;

    // reset in the middle of a clear
    clr_start = 1'b1;
    push(1'b1, 5'd1, 32'h0, 2'd2, 1'b1);
    tick(3'b000, "clr2_start");
    clr_start = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      push(1'b1, 5'(k), 32'h0, 2'd2, 1'b1);
      tick(3'b000, $sformatf("clr2_%0d", k));
    end
    set_req(0, 5'd3, 32'h33333333);
    req_valid = 3'b001;
    rst = 1'b0;
    #1;
    chk("midclr_reset.out", 64'({we3, wa3, wd3, grant_id, clr_busy}), 64'(0));
    chk("midclr_reset.ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(1'b1, 5'd3, 32'h33333333, 2'd0, 1'b0);
    tick(3'b001, "after_reset_req0");
    req_valid = 3'b000;
    push(1'b0, 5'd3, 32'h33333333, 2'd0, 1'b0);
    tick(3'b000, "after_reset_idle");

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register bank's single write port (we3/wa3/wd3) between NREQ writeback requesters using valid/ready handshakes and round-robin arbitration. Also contains a clear sequencer that, on command, zeroes x1..x31 one register per cycle. Sits between the writeback sources (ALU, load unit, debug port) and the register bank. It drives the bank's write inputs directly from registers.

Parameters:
NREQ, 3, number of writeback requesters (2..4)
XLEN, 32, data width
AW, 5, register address width (32 registers)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
req_valid  input  NREQ  request i has a write pending
req_ready  output  NREQ  request i is accepted this cycle (combinational)
req_addr  input  NREQ*AW  packed destination addresses; requester i uses bits [i*AW +: AW]
req_data  input  NREQ*XLEN  packed write data; requester i uses bits [i*XLEN +: XLEN]
clr_start  input  1  pulse: start the clear sequence
clr_busy  output  1  clear sequence in progress
we3  output  1  register bank write enable (registered)
wa3  output  AW  register bank write address (registered)
wd3  output  XLEN  register bank write data (registered)
grant_id  output  2  index of the requester accepted in the previous cycle (registered)

Behaviour:
- Reset values (rst=0, asynchronous): state=RUN, we3=0, wa3=0, wd3=0, grant_id=0, clr_busy=0, rr_ptr=0, clr_cnt=0.
- States:
  - RUN: normal arbitration.
  - CLEAR: sequential zeroing.
- RUN arbitration:
  - Search valid requesters starting at rr_ptr, wrapping modulo NREQ; the first one found wins.
  - req_ready[winner]=1; all other req_ready=0. At most one ready bit is high in any cycle.
  - Handshake completes when valid and ready are both 1 in the same cycle.
  - On a handshake:
    - next cycle: we3=1, wa3=req_addr[winner], wd3=req_data[winner], grant_id=winner.
    - rr_ptr becomes (winner+1) mod NREQ.
  - If no requester is valid: next cycle we3=0; wa3, wd3, grant_id and rr_ptr hold their values.
  - Latency from handshake to write strobe is exactly 1 cycle. Sustained throughput is one write per cycle.
- Writes to address 0:
  - The request is accepted normally (ready asserted, rr_ptr advances).
  - The next cycle has we3=0; wa3 and wd3 are still updated.
- Requester obligations: a requester holds valid, addr and data stable until it is accepted. The arbiter does not check this.
- Entering CLEAR:
  - clr_start=1 while in RUN: all req_ready=0 in that same cycle (clear wins over any simultaneous request). No handshake occurs.
  - Next cycle: state=CLEAR, clr_busy=1, we3=1, wa3=1, wd3=0.
- In CLEAR:
  - wa3 increments by 1 each cycle with we3=1 and wd3=0, covering addresses 1..31 (31 cycles).
  - req_ready stays all 0; requests stay pending.
  - clr_start is ignored.
- Leaving CLEAR:
  - In the cycle after wa3=31 is presented: state=RUN, clr_busy=0, we3=0 unless a handshake occurs in that cycle.
  - rr_ptr is unchanged across the clear.
- Reset during CLEAR aborts the sequence immediately; all values return to reset values.
- grant_id zero-extends the winner index to 2 bits.

Decomposition:
- Package regfile_pkg:
  - constants XLEN=32, AW=5, NREGS=32
  - state typedef enum logic {RUN, CLEAR} wb_state_t
- Sub-module rr_arbiter: inputs NREQ request bits and the pointer; outputs a one-hot grant and the grant index. Purely combinational.
- The FSM, clear counter and output registers stay in the top module.

Test Plan:
- Reset check: rst low mid-run -> we3=0, wa3=0, wd3=0, grant_id=0, clr_busy=0, req_ready=0 immediately and asynchronously.
- Single requester: req0 {addr 5, data 0xDEADBEEF} -> ready0 high the same cycle; next cycle we3=1, wa3=5, wd3=0xDEADBEEF, grant_id=0.
- Round-robin: all three valid continuously from rr_ptr=0 -> grant order 0,1,2,0,1,2. Each requester is granted exactly once per 3 cycles, and never two ready bits at once.
- Address 0: req1 {addr 0, data 0x12345678} -> ready1=1; next cycle we3=0; rr_ptr becomes 2.
- Clear with contention: clr_start together with req2 valid -> ready2=0. Then 31 cycles of we3=1, wa3=1..31, wd3=0, clr_busy=1. req2 is accepted in the first RUN cycle and written one cycle later.
- Reset mid-clear: rst low when wa3=10 -> state=RUN, clr_busy=0, we3=0. After release, a req0 write to address 3 proceeds normally.
